// File: rtl/fm_capture_buffer_pkg.sv
// fm_capture_buffer_pkg
// Shared types and constants for the feature-map capture buffer.
//   fmcap_state_t   : capture FSM state encoding
//   FMCAP_L1_CH/L2_CH: default channel counts for the two observed conv layers
//   fmcap_clog2_min1: $clog2 that never returns 0 (keeps index widths >= 1)
package fm_capture_buffer_pkg;

  typedef enum logic [1:0] {
    FMCAP_IDLE,
    FMCAP_CAPTURE,
    FMCAP_DRAIN
  } fmcap_state_t;

  // Output depths of the conv2d layers in CNN_v1; keep in step with that design.
  localparam int F_OUT_D1 = 15;
  localparam int F_OUT_D2 = 30;

  localparam int FMCAP_L1_CH = F_OUT_D1;
  localparam int FMCAP_L2_CH = F_OUT_D2;

  function automatic int fmcap_clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fm_capture_buffer_ram.sv
// fm_capture_buffer_ram (module fm_capture_ram)
// Single-port DEPTH x WIDTH storage with a registered, enable-gated read.
// The read register only updates on re_i, so the last row read stays on
// rdata_o while the consumer works through its channels.
//   clk_i   : clock
//   we_i    : write enable (wins over re_i)
//   re_i    : read enable
//   addr_i  : shared row address
//   wdata_i : write row
//   rdata_o : registered read row
import fm_capture_buffer_pkg::*;

module fm_capture_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int AW    = 2
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end else if (re_i) begin
      rdata_q <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fm_capture_buffer.sv
// fm_capture_buffer
// Records one feature map (FM_W*FM_H beats of NUM_CH signed channels) and then
// streams it out one channel value per valid/ready handshake, beat-major.
// Optional macro FMCAP_ADDR_CHECK_EN: compare each captured beat's fm_addr_i
// against the running beat count and flag mismatches on addr_err_o.
// Ports:
//   clk_i, rst_i (sync, active-high)
//   arm_i          : start/restart a capture (ignored while draining)
//   fm_valid_i/fm_data_i/fm_addr_i : incoming beats, ch0 in LSBs
//   busy_o         : not idle
//   capture_done_o : one-cycle pulse after the last beat is stored
//   beat_count_o   : beats stored in the current capture
//   dropped_o      : sticky, beat arrived outside capture
//   addr_err_o     : sticky, beat address mismatch (0 without the macro)
//   rd_valid_o/rd_ready_i/rd_data_o/rd_ch_o/rd_idx_o/rd_last_o : readout
import fm_capture_buffer_pkg::*;

module fm_capture_buffer #(
  parameter  int NUM_CH = 15,
  parameter  int DATA_W = 16,
  parameter  int ADDR_W = 10,
  parameter  int FM_W   = 26,
  parameter  int FM_H   = 26,
  localparam int DEPTH  = FM_W * FM_H,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int CH_W   = fmcap_clog2_min1(NUM_CH)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     arm_i,
  input  logic                     fm_valid_i,
  input  logic [NUM_CH*DATA_W-1:0] fm_data_i,
  input  logic [ADDR_W-1:0]        fm_addr_i,
  output logic                     busy_o,
  output logic                     capture_done_o,
  output logic [CNT_W-1:0]         beat_count_o,
  output logic                     dropped_o,
  output logic                     addr_err_o,
  output logic                     rd_valid_o,
  output logic signed [DATA_W-1:0] rd_data_o,
  output logic [CH_W-1:0]          rd_ch_o,
  output logic [CNT_W-1:0]         rd_idx_o,
  output logic                     rd_last_o,
  input  logic                     rd_ready_i
);

  localparam int AW = fmcap_clog2_min1(DEPTH);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);

  fmcap_state_t     state_q, state_d;
  logic [CNT_W-1:0] beat_count_q, beat_count_d;
  logic             done_q, done_d;
  logic             dropped_q, dropped_d;
  logic             addr_err_q, addr_err_d;
  logic             rd_valid_q, rd_valid_d;
  logic [CH_W-1:0]  rd_ch_q, rd_ch_d;
  logic [CNT_W-1:0] rd_idx_q, rd_idx_d;

  logic                     ram_we;
  logic                     ram_re;
  logic [AW-1:0]            ram_addr;
  logic [NUM_CH*DATA_W-1:0] ram_rdata;
  logic                     addr_mismatch;

`ifdef FMCAP_ADDR_CHECK_EN
  localparam int CMP_W = (ADDR_W > CNT_W) ? ADDR_W : CNT_W;
  assign addr_mismatch = (CMP_W'(fm_addr_i) != CMP_W'(beat_count_q));
`else
  logic unused_fm_addr;
  assign unused_fm_addr = ^fm_addr_i;
  assign addr_mismatch  = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    beat_count_d = beat_count_q;
    done_d       = 1'b0;
    dropped_d    = dropped_q;
    addr_err_d   = addr_err_q;
    rd_valid_d   = rd_valid_q;
    rd_ch_d      = rd_ch_q;
    rd_idx_d     = rd_idx_q;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    ram_addr     = beat_count_q[AW-1:0];

    unique case (state_q)
      FMCAP_IDLE: begin
        if (arm_i) begin
          // A beat coinciding with arm is neither stored nor flagged.
          state_d      = FMCAP_CAPTURE;
          beat_count_d = '0;
          dropped_d    = 1'b0;
          addr_err_d   = 1'b0;
        end else if (fm_valid_i) begin
          dropped_d = 1'b1;
        end
      end

      FMCAP_CAPTURE: begin
        if (arm_i) begin
          beat_count_d = '0;
          dropped_d    = 1'b0;
          addr_err_d   = 1'b0;
        end else if (fm_valid_i) begin
          ram_we = 1'b1;
          if (beat_count_q != FULL_CNT) begin
            beat_count_d = beat_count_q + CNT_W'(1);
          end
          if (addr_mismatch) begin
            addr_err_d = 1'b1;
          end
          if (beat_count_q == LAST_BEAT) begin
            state_d    = FMCAP_DRAIN;
            done_d     = 1'b1;
            rd_valid_d = 1'b0;
            rd_idx_d   = '0;
            rd_ch_d    = '0;
          end
        end
      end

      FMCAP_DRAIN: begin
        if (fm_valid_i) begin
          dropped_d = 1'b1;
        end
        ram_addr = rd_idx_q[AW-1:0];
        if (!rd_valid_q) begin
          // Row fetch cycle: the word appears one cycle later.
          ram_re     = 1'b1;
          rd_valid_d = 1'b1;
        end else if (rd_ready_i) begin
          if (rd_ch_q == LAST_CH) begin
            rd_ch_d    = '0;
            rd_valid_d = 1'b0;
            if (rd_idx_q == LAST_BEAT) begin
              state_d  = FMCAP_IDLE;
              rd_idx_d = '0;
            end else begin
              rd_idx_d = rd_idx_q + CNT_W'(1);
            end
          end else begin
            rd_ch_d = rd_ch_q + CH_W'(1);
          end
        end
      end

      default: state_d = FMCAP_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= FMCAP_IDLE;
      beat_count_q <= '0;
      done_q       <= 1'b0;
      dropped_q    <= 1'b0;
      addr_err_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_ch_q      <= '0;
      rd_idx_q     <= '0;
    end else begin
      state_q      <= state_d;
      beat_count_q <= beat_count_d;
      done_q       <= done_d;
      dropped_q    <= dropped_d;
      addr_err_q   <= addr_err_d;
      rd_valid_q   <= rd_valid_d;
      rd_ch_q      <= rd_ch_d;
      rd_idx_q     <= rd_idx_d;
    end
  end

  fm_capture_ram #(
    .DEPTH (DEPTH),
    .WIDTH (NUM_CH * DATA_W),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (fm_data_i),
    .rdata_o (ram_rdata)
  );

  assign busy_o         = (state_q != FMCAP_IDLE);
  assign capture_done_o = done_q;
  assign beat_count_o   = beat_count_q;
  assign dropped_o      = dropped_q;
  assign addr_err_o     = addr_err_q;
  assign rd_valid_o     = rd_valid_q;
  assign rd_ch_o        = rd_ch_q;
  assign rd_idx_o       = rd_idx_q;
  assign rd_last_o      = rd_valid_q && (rd_idx_q == LAST_BEAT) && (rd_ch_q == LAST_CH);
  // RAM output is undefined until the first read, so hold the data bus at 0 when idle.
  assign rd_data_o      = rd_valid_q ? ram_rdata[int'(rd_ch_q)*DATA_W +: DATA_W] : '0;

endmodule

// File: doc/fm_capture_buffer.md
Name: fm_capture_buffer

Overview:
Synthesizable capture buffer for one conv2d layer's visualization port: records one full feature map of FM_W*FM_H beats, each NUM_CH signed channels wide.
Once the map is complete, it streams the stored values out serially, one channel value per handshake.
It sits beside CNN_v1 on the conv2d*_vis_feature_map_* outputs and replaces bench-side queue capture with on-chip debug readout.

Parameters:
NUM_CH, 15, channels per beat (F_OUT_D of the observed layer)
DATA_W, 16, signed bits per channel (FEATURE_MAP_RESOLUTION)
ADDR_W, 10, width of incoming beat address (FEATURE_MAP_ADDRWIDE)
FM_W, 26, feature-map width
FM_H, 26, feature-map height
DEPTH, FM_W*FM_H, derived local: beats per map
CNT_W, $clog2(DEPTH+1), derived local: counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
arm_i  in  1  pulse: start a new capture
fm_valid_i  in  1  feature-map beat valid
fm_data_i  in  NUM_CH*DATA_W  packed channels, ch0 in LSBs, signed
fm_addr_i  in  ADDR_W  beat address from layer
busy_o  out  1  state != IDLE
capture_done_o  out  1  one-cycle pulse when beat DEPTH is stored
beat_count_o  out  CNT_W  beats stored in current capture
dropped_o  out  1  sticky: beat arrived outside CAPTURE
addr_err_o  out  1  sticky address mismatch (see Optional Feature)
rd_valid_o  out  1  readout word valid
rd_data_o  out  DATA_W  readout channel value, signed
rd_ch_o  out  $clog2(NUM_CH)  channel index of rd_data_o
rd_idx_o  out  CNT_W  beat index of rd_data_o
rd_last_o  out  1  last word (beat DEPTH-1, ch NUM_CH-1)
rd_ready_i  in  1  readout consumer ready

Behaviour:
- Reset: state IDLE. All outputs 0. Counters cleared. Sticky flags cleared. RAM contents are don't-care.
- FSM states: IDLE, CAPTURE, DRAIN.
- IDLE -> CAPTURE: on arm_i. Clears beat_count, dropped_o and addr_err_o. A beat valid in the arm cycle is not stored and not flagged.
- CAPTURE: each fm_valid_i writes fm_data_i to RAM[beat_count] and increments beat_count.
- CAPTURE, arm_i again: restarts the capture — count returns to 0 and flags clear; the beat in that cycle is not stored.
- CAPTURE -> DRAIN: the write of beat DEPTH-1 (cycle T) triggers capture_done_o at T+1 and state DRAIN at T+1.
- DRAIN: RAM read of row 0 issued at T+1; rd_valid_o=1 at T+2 with rd_idx_o=0, rd_ch_o=0.
- Readout order: beat-major, channel-minor.
- Readout handshake: a word transfers when rd_valid_o&&rd_ready_i. rd_data_o, rd_ch_o and rd_idx_o stay stable while rd_valid_o&&!rd_ready_i.
- Readout throughput: one word per cycle within a row. After accepting ch NUM_CH-1 of row r at cycle t, rd_valid_o=0 at t+1 and row r+1 ch0 is valid at t+2.
- DRAIN -> IDLE: on the rd_last_o handshake; rd_valid_o drops the next cycle. arm_i is ignored in DRAIN.
- fm_valid_i in IDLE or DRAIN: beat discarded, dropped_o set.
- beat_count_o saturates at DEPTH.
- rst_i mid-capture or mid-drain: immediate return to IDLE, outputs cleared, no partial readout.
- rd_data_o is the stored slice verbatim; no sign extension or arithmetic.

Optional Feature:
- Macro FMCAP_ADDR_CHECK_EN.
- Defined: each captured beat compares fm_addr_i with beat_count (zero-extended to the wider width). On mismatch, addr_err_o is set sticky; the beat is still stored at beat_count.
- Undefined: no comparator; addr_err_o tied 0 and fm_addr_i unused.

Decomposition:
- pkg_parameters gains a typedef enum logic [1:0] {FMCAP_IDLE, FMCAP_CAPTURE, FMCAP_DRAIN} fmcap_state_t, and defaults FMCAP_L1_CH=F_OUT_D1 and FMCAP_L2_CH=F_OUT_D2.
- Sub-module fm_capture_ram: single-port, DEPTH x NUM_CH*DATA_W, synchronous 1-cycle read, write has priority; inferable as block RAM.

Test Plan:
(NUM_CH=4, DATA_W=8, FM_W=FM_H=2, DEPTH=4.)
- Arm, then 4 beats with data {ch3..ch0}={8'h04,8'h03,8'h02,8'h01}+beat*16 and rd_ready_i=1 -> capture_done_o pulses 1 cycle after 4th beat; 16 words 0x01,0x02,0x03,0x04,0x11,… in order; bubble after every 4th word; rd_last_o on word 0x34.
- Same capture with rd_ready_i toggling 1010… -> identical word sequence; outputs stable while stalled.
- Beat valid before arm and during DRAIN -> dropped_o=1; stored data unchanged; beat_count_o=4.
- Arm, 2 beats, arm again, 4 beats with new data -> readout contains only the new 4 beats.
- rst_i asserted on 3rd readout word -> next cycle busy_o=0, rd_valid_o=0; re-arm and capture succeed.
- FMCAP_ADDR_CHECK_EN defined, addresses 0,1,3,3 -> addr_err_o=1 from the beat with addr 3 onward; data still read out intact.
